// File: rtl/cordic_seq.sv
// Sequencer for the pipelined CORDIC sine path: phase accumulator, octant split,
// run control (start/stop/pause/burst) and an index/valid delay line aligned with the pipe.
module cordic_seq #(
    parameter int PHASE_W  = 24,
    parameter int ANG_W    = 16,
    parameter int PIPE_LAT = 16,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic               pause,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [CNT_W-1:0]   burst_len,
    output logic [ANG_W-1:0]   ang_out,
    output logic               wen_pipe,
    output logic [2:0]         idx_qua,
    output logic               wen_qua,
    output logic [CNT_W-1:0]   sample_cnt,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam int DRN_W = $clog2(PIPE_LAT + 1);

    state_t               state_q, state_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   freq_q, freq_d;
    logic [CNT_W-1:0]     burst_q, burst_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DRN_W-1:0]     drn_q, drn_d;
    logic [ANG_W-1:0]     ang_q, ang_d;
    logic                 wen_q, wen_d;
    logic [2:0]           oct_q, oct_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [PIPE_LAT-1:0][3:0] dl_q, dl_d;

    logic [2:0]           oct;
    logic [ANG_W-1:0]     frac;
    logic [CNT_W-1:0]     cnt_inc;

    assign oct     = phase_q[PHASE_W-1 -: 3];
    assign frac    = phase_q[PHASE_W-4 -: ANG_W];
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        freq_d  = freq_q;
        burst_d = burst_q;
        cnt_d   = cnt_q;
        drn_d   = drn_q;
        ang_d   = ang_q;
        wen_d   = 1'b0;
        oct_d   = 3'd0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle is already IDLE, but a start there is dropped so
                // the last drained sample leaves the delay line first.
                if (start && !done_q) begin
                    freq_d  = freq_word;
                    burst_d = burst_len;
                    phase_d = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!pause) begin
                    wen_d   = 1'b1;
                    oct_d   = oct;
                    ang_d   = oct[0] ? ~frac : frac;
                    phase_d = phase_q + freq_q;
                    cnt_d   = cnt_inc;
                end
                if (stop || (!pause && burst_q != '0 && cnt_inc == burst_q)) begin
                    drn_d   = '0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (drn_q == DRN_W'(PIPE_LAT - 1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    drn_d = drn_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // Fed from the registered wen/oct, so a depth of PIPE_LAT gives exactly PIPE_LAT cycles.
    always_comb begin
        dl_d    = dl_q;
        dl_d[0] = {wen_q, oct_q};
        for (int i = 1; i < PIPE_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            freq_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
            drn_q   <= '0;
            ang_q   <= '0;
            wen_q   <= 1'b0;
            oct_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dl_q    <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            freq_q  <= freq_d;
            burst_q <= burst_d;
            cnt_q   <= cnt_d;
            drn_q   <= drn_d;
            ang_q   <= ang_d;
            wen_q   <= wen_d;
            oct_q   <= oct_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dl_q    <= dl_d;
        end
    end

    assign ang_out            = ang_q;
    assign wen_pipe           = wen_q;
    assign {wen_qua, idx_qua} = dl_q[PIPE_LAT-1];
    assign sample_cnt         = cnt_q;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule

// File: tb/tb_cordic_seq.sv
// Randomized scoreboard bench for cordic_seq: expected samples are computed
// arithmetically from the sample number and checked by an independent monitor.
module tb_cordic_seq;

    localparam int PHASE_W  = 24;
    localparam int ANG_W    = 16;
    localparam int PIPE_LAT = 16;
    localparam int CNT_W    = 16;

    logic               clk;
    logic               reset;
    logic               start, stop, pause;
    logic [PHASE_W-1:0] freq_word;
    logic [CNT_W-1:0]   burst_len;
    logic [ANG_W-1:0]   ang_out;
    logic               wen_pipe;
    logic [2:0]         idx_qua;
    logic               wen_qua;
    logic [CNT_W-1:0]   sample_cnt;
    logic               busy;
    logic               done;

    cordic_seq #(.PHASE_W(PHASE_W), .ANG_W(ANG_W), .PIPE_LAT(PIPE_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .freq_word(freq_word), .burst_len(burst_len), .ang_out(ang_out),
        .wen_pipe(wen_pipe), .idx_qua(idx_qua), .wen_qua(wen_qua),
        .sample_cnt(sample_cnt), .busy(busy), .done(done)
    );

    typedef struct { logic [15:0] ang; logic [15:0] cnt; logic [2:0] oct; } samp_t;
    typedef struct { logic [2:0] oct; int cyc; } qua_t;

    samp_t exp_q[$];
    qua_t  qua_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    done_cnt = 0;
    int    exp_done = 0;
    samp_t mon_s;
    qua_t  mon_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sample k (1-based) sits at phase (k-1)*f mod 2^24; odd octants present the complemented fraction.
    function automatic samp_t model(input logic [23:0] f, input int k);
        samp_t s;
        logic [63:0] prod;
        logic [23:0] ph;
        prod  = 64'(k - 1) * 64'(f);
        ph    = prod[23:0];
        s.oct = ph[23:21];
        s.ang = s.oct[0] ? ~ph[20:5] : ph[20:5];
        s.cnt = 16'(k);
        return s;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (wen_pipe) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wen_pipe actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    mon_s = exp_q.pop_front();
                    chk("ang_out", ang_out, mon_s.ang);
                    chk("sample_cnt_live", sample_cnt, mon_s.cnt);
                    mon_q.oct = mon_s.oct;
                    mon_q.cyc = cyc;
                    qua_q.push_back(mon_q);
                end
            end
            if (wen_qua) begin
                if (qua_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_wen_qua actual=1 expected=0 (cycle %0d)", cyc);
                end else begin
                    mon_q = qua_q.pop_front();
                    chk("qua_latency", cyc, mon_q.cyc + PIPE_LAT);
                    chk("idx_qua", idx_qua, mon_q.oct);
                end
            end else if (qua_q.size() != 0 && qua_q[0].cyc + PIPE_LAT <= cyc) begin
                mon_q = qua_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_wen_qua actual=0 expected=1 (cycle %0d)", cyc);
            end
            if (done) done_cnt++;
        end
    end

    task automatic do_run(input logic [23:0] f, input logic [15:0] bl, input int p_at,
                          input int p_len, input int stop_at, input int stop_pz, input bit rnd_pause);
        int k, ci, e_end;
        bit pz, st, ending;
        freq_word = f; burst_len = bl; start = 1'b1;
        step();
        start = 1'b0; freq_word = $urandom; burst_len = 16'($urandom);
        chk("busy_run", busy, 1);
        k = 0; ci = 0; ending = 0;
        while (!ending) begin
            pz = (ci >= p_at && ci < p_at + p_len) || (rnd_pause && $urandom_range(0, 3) == 0);
            st = 1'b0;
            if (ci == stop_pz) begin pz = 1'b1; st = 1'b1; end
            if (!pz && stop_at != 0 && k + 1 == stop_at) st = 1'b1;
            if (ci >= 400) st = 1'b1;
            if (!pz) begin
                k++;
                exp_q.push_back(model(f, k));
            end
            pause = pz; stop = st; start = 1'($urandom_range(0, 1));
            step();
            chk("wen_pipe", wen_pipe, !pz);
            if (st || (!pz && bl != 0 && k == int'(bl))) ending = 1'b1;
            ci++;
        end
        e_end = cyc;
        for (int i = 0; i < PIPE_LAT + 5; i++) begin
            start = 1'($urandom_range(0, 1));
            stop  = 1'($urandom_range(0, 1));
            pause = 1'($urandom_range(0, 1));
            step();
            if (done) break;
        end
        exp_done++;
        chk("done_cycle", cyc, e_end + PIPE_LAT);
        chk("busy_at_done", busy, 0);
        chk("sample_cnt_end", sample_cnt, k[15:0]);
        start = 1'b1; stop = 1'b0; pause = 1'b0;
        step();
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("start_at_done_ignored", busy, 0);
        stop = 1'b1; pause = 1'b1;
        step();
        stop = 1'b0; pause = 1'b0;
        chk("stop_in_idle_ignored", {busy, wen_pipe}, 0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        freq_word = '0; burst_len = '0;
        repeat (3) step();
        chk("in_reset_zero", {ang_out, wen_pipe, idx_qua, wen_qua, sample_cnt, busy, done}, 0);
        reset = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("idle_zero", {ang_out, wen_pipe, idx_qua, wen_qua, sample_cnt, busy, done}, 0);
        end

        do_run(24'h200000, 16'd8, -1, 0, 0, -1, 1'b0);
        do_run(24'h080000, 16'd40, -1, 0, 0, -1, 1'b0);
        do_run(24'($urandom), 16'd0, 8, 5, 20, -1, 1'b0);
        do_run(24'($urandom), 16'd1, -1, 0, 0, -1, 1'b0);
        do_run(24'($urandom), 16'd0, -1, 0, 0, 6, 1'b0);
        do_run(24'($urandom), 16'd10, 9, 3, 0, -1, 1'b0);
        for (int r = 0; r < 6; r++) begin
            do_run(24'($urandom), 16'($urandom_range(1, 25)), -1, 0, 0, -1, 1'b1);
        end

        // Reset in the middle of a continuous run, right after sample 3.
        freq_word = 24'h123456; burst_len = 16'd0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            exp_q.push_back(model(24'h123456, k));
            step();
        end
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        exp_q.delete();
        qua_q.delete();
        chk("reset_async_zero", {ang_out, wen_pipe, idx_qua, wen_qua, sample_cnt, busy, done}, 0);
        step();
        chk("reset_edge_zero", {ang_out, wen_pipe, idx_qua, wen_qua, sample_cnt, busy, done}, 0);
        reset = 1'b1;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 2 * PIPE_LAT; i++) begin
                step();
                if (wen_qua || wen_pipe || busy) seen++;
            end
            chk("no_activity_after_reset", seen, 0);
        end

        chk("exp_q_empty", exp_q.size(), 0);
        chk("qua_q_empty", qua_q.size(), 0);
        chk("done_count", done_cnt, exp_done);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
